reg_file_master: RTL

REG_FILE_MASTER -- requirements
Module: reg_file_master

---
 rtl/reg_file_pkg.sv | 21 ++
 rtl/reg_file_master.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/reg_file_pkg.sv
// Shared defaults and FSM state encoding for reg_file_master.
// The INIT state exists only when REG_FILE_MASTER_INIT_EN is defined.
package reg_file_pkg;

  localparam int REG_DATA_W   = 16;
  localparam int REG_ADDR_W   = 3;
  localparam int REG_NUM_REGS = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    CAP  = 3'd3,
    RSP  = 3'd4
`ifdef REG_FILE_MASTER_INIT_EN
    ,
    INIT = 3'd5
`endif
  } state_e;

endpackage

// File: rtl/reg_file_master.sv
// Command/response master for a sync-write, registered-read register file.
// Optional power-up clear of every register when REG_FILE_MASTER_INIT_EN is defined.
//
// state | meaning
// INIT  | clear sequence: write 0 to addresses 0..NUM_REGS-1 (optional)
// IDLE  | cmd_ready high, waiting for a command
// WR    | WrEn high for one cycle with latched Address/WrData
// RD    | RdEn high for one cycle with latched Address
// CAP   | register file read data valid, captured at end of cycle
// RSP   | rsp_valid high, held until rsp_ready
module reg_file_master
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_REGS = REG_NUM_REGS
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [DATA_W-1:0] WrData,
  output logic [ADDR_W-1:0] Address,
  output logic              WrEn,
  output logic              RdEn,
  input  logic [DATA_W-1:0] RdData
);

  if (NUM_REGS != (1 << ADDR_W)) begin : g_cfg_err
    $error("reg_file_master: NUM_REGS must equal 2**ADDR_W");
  end

`ifdef REG_FILE_MASTER_INIT_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
`endif

  state_e            state_q, state_d;
  logic              live_q, live_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      live_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= live_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    live_d    = 1'b1;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    WrEn      = 1'b0;
    RdEn      = 1'b0;
    busy      = 1'b1;

    // live_q stays low through reset so every output holds its reset value
    // until the first edge after release, which picks the start state.
    if (!live_q) begin
`ifdef REG_FILE_MASTER_INIT_EN
      state_d = INIT;
      addr_d  = '0;
      wdata_d = '0;
`else
      state_d = IDLE;
`endif
    end else begin
      unique case (state_q)
`ifdef REG_FILE_MASTER_INIT_EN
        INIT: begin
          WrEn = 1'b1;
          if (addr_q == LAST_ADDR) begin
            state_d = IDLE;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
`endif
        IDLE: begin
          cmd_ready = 1'b1;
          busy      = 1'b0;
          if (cmd_valid) begin
            addr_d = cmd_addr;
            if (cmd_write) begin
              wdata_d = cmd_wdata;
              state_d = WR;
            end else begin
              state_d = RD;
            end
          end
        end
        WR: begin
          WrEn    = 1'b1;
          state_d = IDLE;
        end
        RD: begin
          RdEn    = 1'b1;
          state_d = CAP;
        end
        CAP: begin
          rdata_d = RdData;
          state_d = RSP;
        end
        RSP: begin
          rsp_valid = 1'b1;
          if (rsp_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign Address   = addr_q;
  assign WrData    = wdata_q;
  assign rsp_rdata = rdata_q;

endmodule
